lzw_dict_datapath: RTL and testbench
====================================

LZW_DICT_DATAPATH -- requirements
Module: lzw_dict_datapath

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, meaning symbol width in bits.
REQ-002 SHALL have parameter MAX_CHARS, default 16, meaning string register capacity in symbols (even, 2..64).
REQ-003 SHALL have parameter CODE_W, default 12, meaning code counter width.
REQ-004 SHALL have parameter ADDR_W, default 18, meaning dictionary RAM address width.
REQ-005 SHALL have parameter RAM_W, default 16 (= 2*CHAR_W), meaning dictionary RAM word width.
REQ-006 SHALL have port Clk, input, 1, meaning the single clock; all state on rising edge.
REQ-007 SHALL have port Rst, input, 1, meaning the synchronous active-high reset.
REQ-008 SHALL have port cmd, input, 4, meaning the opcode per REQ-015, sampled every cycle.
REQ-009 SHALL have port in_data, input, ADDR_W, meaning the buffer data (symbol in [CHAR_W-1:0], init pointer as a full word).
REQ-010 SHALL have port in_req, output, 1, meaning a combinational pulse when cmd consumes in_data.
REQ-011 SHALL have ports ram_rd_req (output, 1), ram_addr (output, ADDR_W), ram_rd_valid (input, 1) and ram_rd_data (input, RAM_W), meaning the dictionary read handshake.
REQ-012 SHALL have ports code_out (output, CODE_W), str_len (output, log2(MAX_CHARS)+1), dic_ptr (output, ADDR_W) and ins_ptr (output, ADDR_W), meaning register observation.
REQ-013 SHALL have flag outputs, each 1 bit: busy, match, str_full, code_full, dic_eq_ins, dic_eq_jump, entry_empty and err.

Function
REQ-014 SHALL execute cmd only when busy=0; cmd while busy SHALL be ignored and SHALL set err (sticky until Rst or CLR_ERR).
REQ-015 SHALL use opcodes 0 NOP, 1 STR_CLR, 2 STR_LOAD_CHAR, 3 STR_LOAD_BUF, 4 STR_APPEND, 5 STR_DROP, 6 CHAR_LOAD, 7 CODE_CLR, 8 CODE_INC, 9 DIC_INIT_LOAD, 10 DIC_LOAD, 11 DIC_INC, 12 INS_LOAD, 13 INS_UPDATE, 14 FETCH, 15 CLR_ERR.
REQ-016 SHALL, on STR_LOAD_CHAR/STR_LOAD_BUF, set the string to one symbol (char reg / in_data) with len=1.
REQ-017 SHALL, on STR_APPEND, shift the string left one symbol, insert char reg and increment len; at len=MAX_CHARS it SHALL leave the string unchanged and set err.
REQ-018 SHALL, on STR_DROP, discard the oldest symbol and decrement len; at len=0 it SHALL be a no-op without err.
REQ-019 SHALL set str_full when len==MAX_CHARS.
REQ-020 SHALL, on CODE_INC, increment code; at all-ones it SHALL hold (no wrap), with code_full=1 while code is all-ones.
REQ-021 SHALL, on INS_UPDATE, set ins_ptr += 1 + ceil(len/2), modulo 2^ADDR_W.
REQ-022 SHALL, on DIC_INIT_LOAD, latch in_data as init pointer; DIC_LOAD SHALL copy it to dic_ptr; DIC_INC SHALL add 1 modulo 2^ADDR_W.
REQ-023 SHALL, on FETCH, run the FSM IDLE->HDR->DATA->DONE->IDLE, with busy=1 outside IDLE.
REQ-024 SHALL, in HDR, hold ram_rd_req=1 with ram_addr=dic_ptr until ram_rd_valid, latching entry length = ram_rd_data[7:0].
REQ-025 SHALL go from HDR to DONE if entry length is 0 (entry_empty=1); otherwise to DATA.
REQ-026 SHALL, in DATA, read ceil(len/2) words at dic_ptr+1.., two symbols per word (low byte first), then go to DONE.
REQ-027 SHALL, in DONE, for one cycle: set match=(entry len==len and all symbols equal), jump=dic_ptr+1+ceil(entry len/2), dic_ptr=jump, then return to IDLE.
REQ-028 SHALL treat entry length > MAX_CHARS as err plus match=0, with the words still consumed.
REQ-029 SHALL keep ram_rd_req low in IDLE/DONE and issue at most one outstanding read.
REQ-030 SHALL drive dic_eq_ins=(dic_ptr==ins_ptr) and dic_eq_jump=(dic_ptr==jump) combinationally.
REQ-031 SHALL assert in_req exactly for opcodes 3, 6 and 9 accepted in IDLE.

Reset
REQ-032 SHALL, on Rst, clear all registers, outputs and flags to 0 and the FSM to IDLE, aborting any fetch mid-operation and dropping a later ram_rd_valid.
REQ-033 SHALL give Rst priority over cmd in the same cycle.

Structure
REQ-034 SHALL place the opcode enum, FSM state encoding and the ceil-half length function in the shared package lzw_pkg.
REQ-035 SHALL implement the fetch FSM and comparator as the sub-module lzw_entry_fetch.

Verification
REQ-036 SHALL cover: STR_LOAD_BUF 0x41, CHAR_LOAD 0x42, STR_APPEND -> len=2, string "AB".
REQ-037 SHALL cover: 16 STR_APPENDs after a load -> str_full=1, err=1, len=16.
REQ-038 SHALL cover: RAM at 0x100 = {len 2}, {0x42,0x41}; dic_ptr=0x100, string "AB", FETCH -> match=1, dic_ptr=0x102.
REQ-039 SHALL cover: FETCH of a len=0 header -> entry_empty=1, match=0, dic_ptr+=1.
REQ-040 SHALL cover: CODE_INC from 0xFFE twice -> code=0xFFF, code_full=1.
REQ-041 SHALL cover: Rst during DATA -> busy=0 next cycle, a late ram_rd_valid is ignored.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW dictionary datapath: opcodes, fetch states
// and the half-length rounding used for word counts.
package lzw_pkg;

  typedef enum logic [3:0] {
    OP_NOP           = 4'd0,
    OP_STR_CLR       = 4'd1,
    OP_STR_LOAD_CHAR = 4'd2,
    OP_STR_LOAD_BUF  = 4'd3,
    OP_STR_APPEND    = 4'd4,
    OP_STR_DROP      = 4'd5,
    OP_CHAR_LOAD     = 4'd6,
    OP_CODE_CLR      = 4'd7,
    OP_CODE_INC      = 4'd8,
    OP_DIC_INIT_LOAD = 4'd9,
    OP_DIC_LOAD      = 4'd10,
    OP_DIC_INC       = 4'd11,
    OP_INS_LOAD      = 4'd12,
    OP_INS_UPDATE    = 4'd13,
    OP_FETCH         = 4'd14,
    OP_CLR_ERR       = 4'd15
  } lzw_op_e;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_HDR  = 2'd1,
    FS_DATA = 2'd2,
    FS_DONE = 2'd3
  } fetch_state_e;

  // Number of two-symbol words needed for n symbols; 9-bit sum so n=255 works.
  function automatic logic [7:0] ceil_half(input logic [7:0] n);
    logic [8:0] t;
    t = {1'b0, n} + 9'd1;
    return t[8:1];
  endfunction

endpackage

// File: rtl/lzw_entry_fetch.sv
// Dictionary entry fetch: reads the header word and the packed symbol words
// of one entry, compares them against the current string and computes the
// pointer to the following entry.
module lzw_entry_fetch
  import lzw_pkg::*;
#(
  parameter int CHAR_W    = 8,
  parameter int MAX_CHARS = 16,
  parameter int ADDR_W    = 18,
  parameter int RAM_W     = 16,
  parameter int LEN_W     = 5
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   dic_ptr,
  input  logic [MAX_CHARS-1:0][CHAR_W-1:0]    str,
  input  logic [LEN_W-1:0]                    str_len,
  output logic                                ram_rd_req,
  output logic [ADDR_W-1:0]                   ram_addr,
  input  logic                                ram_rd_valid,
  input  logic [RAM_W-1:0]                    ram_rd_data,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_W-1:0]                   next_ptr,
  output logic [ADDR_W-1:0]                   jump,
  output logic                                match,
  output logic                                entry_empty,
  output logic                                len_err
);

  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  fetch_state_e      state_q, state_d;
  logic [7:0]        elen_q, elen_d;
  logic [7:0]        widx_q, widx_d;
  logic              mism_q, mism_d;
  logic              match_q, match_d;
  logic              empty_q, empty_d;
  logic [ADDR_W-1:0] jump_q, jump_d;
  logic [7:0]        nwords;
  logic [7:0]        str_len8;
  logic [1:0]        sym_ne;
  logic              last_word;

  assign str_len8  = 8'(str_len);
  assign nwords    = ceil_half(elen_q);
  assign last_word = ((widx_q + 8'd1) == nwords);
  assign next_ptr  = dic_ptr + ADDR_W'(1) + ADDR_W'(nwords);

  // Entry symbol k (oldest first) lines up with string slot len-1-k, since the
  // string register keeps its newest symbol in slot 0.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sym
      logic [8:0] k;
      logic [8:0] ridx;
      logic       live;
      assign k    = {widx_q, 1'b0} + 9'(gi);
      assign live = (k < {1'b0, elen_q}) && (k < {1'b0, str_len8});
      assign ridx = {1'b0, str_len8} - 9'd1 - k;
      assign sym_ne[gi] = live &&
          (ram_rd_data[gi*CHAR_W +: CHAR_W] != str[ridx[IDX_W-1:0]]);
    end
  endgenerate

  // Next-state, read request and compare accumulation.
  always_comb begin
    state_d    = state_q;
    elen_d     = elen_q;
    widx_d     = widx_q;
    mism_d     = mism_q;
    match_d    = match_q;
    empty_d    = empty_q;
    jump_d     = jump_q;
    ram_rd_req = 1'b0;
    ram_addr   = dic_ptr;
    done       = 1'b0;
    len_err    = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (start) begin
          state_d = FS_HDR;
          elen_d  = 8'd0;
          widx_d  = 8'd0;
          mism_d  = 1'b0;
          match_d = 1'b0;
          empty_d = 1'b0;
        end
      end
      FS_HDR: begin
        ram_rd_req = 1'b1;
        if (ram_rd_valid) begin
          elen_d  = ram_rd_data[7:0];
          empty_d = (ram_rd_data[7:0] == 8'd0);
          state_d = (ram_rd_data[7:0] == 8'd0) ? FS_DONE : FS_DATA;
        end
      end
      FS_DATA: begin
        ram_rd_req = 1'b1;
        ram_addr   = dic_ptr + ADDR_W'(1) + ADDR_W'(widx_q);
        if (ram_rd_valid) begin
          if (|sym_ne) mism_d = 1'b1;
          widx_d = widx_q + 8'd1;
          if (last_word) state_d = FS_DONE;
        end
      end
      FS_DONE: begin
        done    = 1'b1;
        jump_d  = next_ptr;
        len_err = (elen_q > 8'(MAX_CHARS));
        // An empty entry is a terminator and never matches.
        match_d = !empty_q && !mism_q && (elen_q == str_len8) &&
                  (elen_q <= 8'(MAX_CHARS));
        state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // State registers; reset aborts any fetch in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= FS_IDLE;
      elen_q  <= '0;
      widx_q  <= '0;
      mism_q  <= 1'b0;
      match_q <= 1'b0;
      empty_q <= 1'b0;
      jump_q  <= '0;
    end else begin
      state_q <= state_d;
      elen_q  <= elen_d;
      widx_q  <= widx_d;
      mism_q  <= mism_d;
      match_q <= match_d;
      empty_q <= empty_d;
      jump_q  <= jump_d;
    end
  end

  assign busy        = (state_q != FS_IDLE);
  assign match       = match_q;
  assign entry_empty = empty_q;
  assign jump        = jump_q;

endmodule

// File: rtl/lzw_dict_datapath.sv
// LZW dictionary datapath: string/char/code/pointer registers driven by a
// 4-bit command, plus the entry fetch engine for dictionary lookups.
module lzw_dict_datapath
  import lzw_pkg::*;
#(
  parameter int CHAR_W    = 8,
  parameter int MAX_CHARS = 16,
  parameter int CODE_W    = 12,
  parameter int ADDR_W    = 18,
  parameter int RAM_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [3:0]                   cmd,
  input  logic [ADDR_W-1:0]            in_data,
  output logic                         in_req,
  output logic                         ram_rd_req,
  output logic [ADDR_W-1:0]            ram_addr,
  input  logic                         ram_rd_valid,
  input  logic [RAM_W-1:0]             ram_rd_data,
  output logic [CODE_W-1:0]            code_out,
  output logic [$clog2(MAX_CHARS):0]   str_len,
  output logic [ADDR_W-1:0]            dic_ptr,
  output logic [ADDR_W-1:0]            ins_ptr,
  output logic                         busy,
  output logic                         match,
  output logic                         str_full,
  output logic                         code_full,
  output logic                         dic_eq_ins,
  output logic                         dic_eq_jump,
  output logic                         entry_empty,
  output logic                         err
);

  localparam int LEN_W = $clog2(MAX_CHARS) + 1;
  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  logic [MAX_CHARS-1:0][CHAR_W-1:0] str_q, str_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [CHAR_W-1:0]                char_q, char_d;
  logic [CODE_W-1:0]                code_q, code_d;
  logic [ADDR_W-1:0]                init_q, init_d;
  logic [ADDR_W-1:0]                dic_q, dic_d;
  logic [ADDR_W-1:0]                ins_q, ins_d;
  logic                             err_q, err_d;

  lzw_op_e           op;
  logic              fetch_start, fetch_done, fetch_len_err;
  logic [ADDR_W-1:0] next_ptr, jump;
  logic [LEN_W-1:0]  len_m1;
  logic              full;

  assign op          = lzw_op_e'(cmd);
  assign len_m1      = len_q - LEN_W'(1);
  assign full        = (len_q == LEN_W'(MAX_CHARS));
  assign fetch_start = !busy && (op == OP_FETCH);
  assign in_req      = !busy && ((op == OP_STR_LOAD_BUF) || (op == OP_CHAR_LOAD) ||
                                 (op == OP_DIC_INIT_LOAD));

  lzw_entry_fetch #(
    .CHAR_W(CHAR_W), .MAX_CHARS(MAX_CHARS), .ADDR_W(ADDR_W),
    .RAM_W(RAM_W), .LEN_W(LEN_W)
  ) u_fetch (
    .Clk(Clk), .Rst(Rst), .start(fetch_start), .dic_ptr(dic_q),
    .str(str_q), .str_len(len_q),
    .ram_rd_req(ram_rd_req), .ram_addr(ram_addr),
    .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
    .busy(busy), .done(fetch_done), .next_ptr(next_ptr), .jump(jump),
    .match(match), .entry_empty(entry_empty), .len_err(fetch_len_err)
  );

  // Command decode; commands arriving during a fetch only raise err.
  always_comb begin
    str_d  = str_q;
    len_d  = len_q;
    char_d = char_q;
    code_d = code_q;
    init_d = init_q;
    dic_d  = dic_q;
    ins_d  = ins_q;
    err_d  = err_q;
    if (fetch_done)    dic_d = next_ptr;
    if (fetch_len_err) err_d = 1'b1;
    if (busy) begin
      if (op != OP_NOP) err_d = 1'b1;
    end else begin
      case (op)
        OP_STR_CLR:       begin str_d = '0; len_d = '0; end
        OP_STR_LOAD_CHAR: begin str_d = '0; str_d[0] = char_q; len_d = LEN_W'(1); end
        OP_STR_LOAD_BUF:  begin str_d = '0; str_d[0] = in_data[CHAR_W-1:0]; len_d = LEN_W'(1); end
        OP_STR_APPEND: begin
          if (full) err_d = 1'b1;
          else begin
            str_d = {str_q[MAX_CHARS-2:0], char_q};
            len_d = len_q + LEN_W'(1);
          end
        end
        OP_STR_DROP: begin
          // Oldest symbol sits at slot len-1.
          if (len_q != '0) begin
            str_d[len_m1[IDX_W-1:0]] = '0;
            len_d = len_m1;
          end
        end
        OP_CHAR_LOAD:     char_d = in_data[CHAR_W-1:0];
        OP_CODE_CLR:      code_d = '0;
        OP_CODE_INC:      if (!(&code_q)) code_d = code_q + CODE_W'(1);
        OP_DIC_INIT_LOAD: init_d = in_data;
        OP_DIC_LOAD:      dic_d  = init_q;
        OP_DIC_INC:       dic_d  = dic_q + ADDR_W'(1);
        // The insertion point is taken from where the dictionary walk stopped.
        OP_INS_LOAD:      ins_d  = dic_q;
        OP_INS_UPDATE:    ins_d  = ins_q + ADDR_W'(1) + ADDR_W'(ceil_half(8'(len_q)));
        OP_CLR_ERR:       err_d  = 1'b0;
        default: ;
      endcase
    end
  end

  // Register file update with synchronous reset taking priority over cmd.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      str_q  <= '0;
      len_q  <= '0;
      char_q <= '0;
      code_q <= '0;
      init_q <= '0;
      dic_q  <= '0;
      ins_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      str_q  <= str_d;
      len_q  <= len_d;
      char_q <= char_d;
      code_q <= code_d;
      init_q <= init_d;
      dic_q  <= dic_d;
      ins_q  <= ins_d;
      err_q  <= err_d;
    end
  end

  assign code_out    = code_q;
  assign str_len     = len_q;
  assign dic_ptr     = dic_q;
  assign ins_ptr     = ins_q;
  assign str_full    = full;
  assign code_full   = &code_q;
  assign dic_eq_ins  = (dic_q == ins_q);
  assign dic_eq_jump = (dic_q == jump);
  assign err         = err_q;

endmodule

// File: tb/tb_lzw_dict_datapath.sv
// Directed bench for lzw_dict_datapath: a queue-based model of the string and
// register set, a dictionary RAM responder with fixed latency, a per-cycle
// compare process and literal checks on the key scenarios.
module tb_lzw_dict_datapath;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  cmd;
  logic [17:0] in_data;
  logic        in_req, ram_rd_req;
  logic [17:0] ram_addr;
  logic        ram_rd_valid = 1'b0;
  logic [15:0] ram_rd_data  = 16'hDEAD;
  logic [11:0] code_out;
  logic [4:0]  str_len;
  logic [17:0] dic_ptr, ins_ptr;
  logic busy, match, str_full, code_full, dic_eq_ins, dic_eq_jump, entry_empty, err;

  always #5 Clk = ~Clk;

  lzw_dict_datapath dut (
    .Clk(Clk), .Rst(Rst), .cmd(cmd), .in_data(in_data), .in_req(in_req),
    .ram_rd_req(ram_rd_req), .ram_addr(ram_addr), .ram_rd_valid(ram_rd_valid),
    .ram_rd_data(ram_rd_data), .code_out(code_out), .str_len(str_len),
    .dic_ptr(dic_ptr), .ins_ptr(ins_ptr), .busy(busy), .match(match),
    .str_full(str_full), .code_full(code_full), .dic_eq_ins(dic_eq_ins),
    .dic_eq_jump(dic_eq_jump), .entry_empty(entry_empty), .err(err)
  );

  // Model state: string held oldest-first in a queue.
  logic [7:0]  m_s[$];
  logic [7:0]  m_ch;
  logic [11:0] m_code;
  logic [17:0] m_init, m_dic, m_ins, m_jump;
  logic        m_err, m_match, m_empty;
  bit          chk_en = 0;
  int          vecs = 0, errs = 0;

  logic [15:0] mem [logic [17:0]];
  logic [17:0] addrq[$];
  int          pend = 0;
  logic [17:0] paddr;

  function automatic logic [15:0] rd(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s.delete();
    m_ch = 0; m_code = 0; m_init = 0; m_dic = 0; m_ins = 0; m_jump = 0;
    m_err = 0; m_match = 0; m_empty = 0;
  endtask

  // Dictionary RAM: one read at a time, data two cycles after the request.
  always @(posedge Clk) begin
    #1;
    ram_rd_valid = 1'b0;
    ram_rd_data  = 16'hDEAD;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ram_rd_valid = 1'b1;
        ram_rd_data  = rd(paddr);
      end
    end else if (ram_rd_req === 1'b1) begin
      paddr = ram_addr;
      addrq.push_back(ram_addr);
      pend = 2;
    end
  end

  // Every idle cycle: all observation outputs against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", busy, 0);
      check("ram_rd_req", ram_rd_req, 0);
      check("code_out", code_out, m_code);
      check("str_len", str_len, m_s.size());
      check("dic_ptr", dic_ptr, m_dic);
      check("ins_ptr", ins_ptr, m_ins);
      check("match", match, m_match);
      check("str_full", str_full, m_s.size() == 16);
      check("code_full", code_full, m_code == 12'hFFF);
      check("dic_eq_ins", dic_eq_ins, m_dic == m_ins);
      check("dic_eq_jump", dic_eq_jump, m_dic == m_jump);
      check("entry_empty", entry_empty, m_empty);
      check("err", err, m_err);
    end
  end

  task automatic do_reset();
    chk_en = 0;
    @(negedge Clk);
    Rst = 1'b1; cmd = 4'd8; in_data = 18'h0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0; cmd = 4'd0;
    model_reset();
    chk_en = 1;
    $display("[%0t] reset", $time);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [17:0] data, input bit quiet);
    @(negedge Clk);
    cmd = op; in_data = data;
    #1;
    check("in_req", in_req, (op == 4'd3) || (op == 4'd6) || (op == 4'd9));
    @(posedge Clk);
    #1;
    cmd = 4'd0;
    case (op)
      4'd1:  m_s.delete();
      4'd2:  begin m_s.delete(); m_s.push_back(m_ch); end
      4'd3:  begin m_s.delete(); m_s.push_back(data[7:0]); end
      4'd4:  if (m_s.size() == 16) m_err = 1; else m_s.push_back(m_ch);
      4'd5:  if (m_s.size() > 0) void'(m_s.pop_front());
      4'd6:  m_ch = data[7:0];
      4'd7:  m_code = 0;
      4'd8:  if (m_code != 12'hFFF) m_code = m_code + 12'd1;
      4'd9:  m_init = data;
      4'd10: m_dic = m_init;
      4'd11: m_dic = m_dic + 18'd1;
      4'd12: m_ins = m_dic;
      4'd13: m_ins = m_ins + 18'(1 + (m_s.size() + 1) / 2);
      4'd15: m_err = 0;
      default: ;
    endcase
    if (!quiet) $display("[%0t] cmd=%0d data=%0h len=%0d", $time, op, data, m_s.size());
  endtask

  // FETCH at the model's dic pointer; optionally issue one command while busy.
  task automatic do_fetch(input logic [3:0] interfere);
    int elen, nw, cyc;
    bit eq;
    logic [15:0] w;
    logic [7:0]  sym;
    w    = rd(m_dic);
    elen = int'(w[7:0]);
    nw   = (elen + 1) / 2;
    eq   = (elen != 0) && (elen == m_s.size());
    for (int k = 0; k < elen; k++) begin
      w   = rd(m_dic + 18'(1 + k / 2));
      sym = (k % 2 == 1) ? w[15:8] : w[7:0];
      if (k < m_s.size() && sym != m_s[k]) eq = 0;
    end
    addrq.delete();
    chk_en = 0;
    @(negedge Clk);
    cmd = 4'd14;
    #1;
    check("in_req_fetch", in_req, 0);
    @(posedge Clk);
    #1;
    cmd = 4'd0;
    cyc = 0;
    do begin
      @(negedge Clk);
      if (cyc == 0 && interfere != 4'd0) begin
        cmd = interfere; in_data = 18'h5A;
        #1;
        check("in_req_busy", in_req, 0);
      end else begin
        cmd = 4'd0;
      end
      cyc++;
    end while (busy === 1'b1 && cyc < 300);
    cmd = 4'd0;
    check("fetch_finished", busy, 0);
    check("rd_count", addrq.size(), nw + 1);
    for (int i = 0; i <= nw; i++)
      if (i < addrq.size()) check("rd_addr", addrq[i], m_dic + 18'(i));
    m_match = eq;
    m_empty = (elen == 0);
    m_jump  = m_dic + 18'(1 + nw);
    m_dic   = m_jump;
    if (elen > 16) m_err = 1;
    if (interfere != 4'd0) m_err = 1;
    chk_en = 1;
    $display("[%0t] fetch elen=%0d match=%0b next=%0h", $time, elen, eq, m_dic);
  endtask

  initial begin
    int cyc;
    Rst = 1'b0; cmd = 4'd0; in_data = 18'h0;
    model_reset();
    do_reset();
    @(negedge Clk);
    check("rst_code", code_out, 0);
    check("rst_dic_eq_jump", dic_eq_jump, 1);

    // "AB" built from buffer load and char append
    do_cmd(4'd3, 18'h41, 0);
    do_cmd(4'd6, 18'h42, 0);
    do_cmd(4'd4, 18'h0, 0);
    check("ab_len", str_len, 2);

    // Matching entry at 0x100
    mem[18'h100] = 16'h0002;
    mem[18'h101] = 16'h4241;
    do_cmd(4'd9, 18'h100, 0);
    do_cmd(4'd10, 18'h0, 0);
    check("dic_loaded", dic_ptr, 18'h100);
    do_fetch(4'd0);
    check("ab_match", match, 1);
    check("ab_dic", dic_ptr, 18'h102);

    // Empty header (upper byte must be ignored)
    mem[18'h102] = 16'hAB00;
    do_fetch(4'd0);
    check("empty_flag", entry_empty, 1);
    check("empty_match", match, 0);
    check("empty_dic", dic_ptr, 18'h103);

    // Same length, different symbols
    mem[18'h103] = 16'h0002;
    mem[18'h104] = 16'h4141;
    do_fetch(4'd0);
    check("aa_match", match, 0);
    check("aa_dic", dic_ptr, 18'h105);

    // Odd length "ABC", spare high byte ignored, load attempted while busy
    do_cmd(4'd6, 18'h43, 0);
    do_cmd(4'd4, 18'h0, 0);
    mem[18'h105] = 16'h0003;
    mem[18'h106] = 16'h4241;
    mem[18'h107] = 16'h7743;
    do_fetch(4'd3);
    check("abc_match", match, 1);
    check("abc_busy_err", err, 1);
    check("abc_dic", dic_ptr, 18'h108);
    do_cmd(4'd15, 18'h0, 0);

    // Oversize entry: 20 symbols, all ten words still read
    mem[18'h108] = 16'h0014;
    for (int i = 0; i < 10; i++) mem[18'h109 + 18'(i)] = 16'h4241;
    do_fetch(4'd0);
    check("big_err", err, 1);
    check("big_match", match, 0);
    check("big_dic", dic_ptr, 18'h113);
    do_cmd(4'd15, 18'h0, 0);

    // Insertion pointer
    do_cmd(4'd12, 18'h0, 0);
    check("ins_eq", dic_eq_ins, 1);
    do_cmd(4'd13, 18'h0, 0);
    check("ins_upd", ins_ptr, 18'h116);
    repeat (3) do_cmd(4'd11, 18'h0, 0);
    check("dic_inc_eq", dic_eq_ins, 1);

    // Drops down to empty and one more
    repeat (4) do_cmd(4'd5, 18'h0, 0);
    check("drop_len", str_len, 0);
    check("drop_err", err, 0);

    // Overfill
    do_cmd(4'd2, 18'h0, 0);
    repeat (16) do_cmd(4'd4, 18'h0, 0);
    check("full_len", str_len, 16);
    check("full_flag", str_full, 1);
    check("full_err", err, 1);
    do_cmd(4'd1, 18'h0, 0);
    do_cmd(4'd15, 18'h0, 0);

    // Code counter saturation
    do_cmd(4'd7, 18'h0, 0);
    repeat (4094) do_cmd(4'd8, 18'h0, 1);
    check("code_ffe", code_out, 12'hFFE);
    do_cmd(4'd8, 18'h0, 0);
    do_cmd(4'd8, 18'h0, 0);
    check("code_fff", code_out, 12'hFFF);
    check("code_full_lit", code_full, 1);

    // Reset in the middle of the data words, CODE_INC alongside it
    mem[18'h200] = 16'h0004;
    mem[18'h201] = 16'h1111;
    mem[18'h202] = 16'h2222;
    do_cmd(4'd9, 18'h200, 0);
    do_cmd(4'd10, 18'h0, 0);
    chk_en = 0;
    addrq.delete();
    @(negedge Clk);
    cmd = 4'd14;
    @(posedge Clk);
    #1;
    cmd = 4'd0;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (addrq.size() < 2 && cyc < 100);
    check("reached_data", addrq.size() >= 2, 1);
    Rst = 1'b1; cmd = 4'd8;
    @(posedge Clk);
    #1;
    Rst = 1'b0; cmd = 4'd0;
    model_reset();
    @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_req", ram_rd_req, 0);
    chk_en = 1;
    repeat (6) @(negedge Clk);
    check("late_valid_dic", dic_ptr, 0);
    check("late_valid_code", code_out, 0);
    $display("[%0t] reset during fetch", $time);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
